hazard_unit: RTL
================

# hazard_unit

Interlock and forwarding controller for the five-stage RISC-V pipeline. It is the control side of the decode/execute pipeline register: it reads the decode-stage operands that are about to be latched and drives stall and flush back into PC, IF/DE and DE/EX. It also selects forwarding paths for the EX-stage ALU operands. It keeps its own shadow pipeline of in-flight destination registers (EX, MEM, WB slots) and saturating hazard-statistics counters.

## Interface
- FORWARDING, 1: 1 = forwarding paths exist and only load-use stalls; 0 = stall on any RAW against EX/MEM.
- CNT_W, 32: width of statistics counters.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- de_valid  in  1  decode stage holds a real instruction.
- de_rs1, de_rs2  in  5  decode source registers.
- de_rs1_used, de_rs2_used  in  1  source actually read by the instruction.
- de_rd  in  5  decode destination.
- de_ru_write  in  1  decode instruction writes the register file.
- de_ru_data_src  in  2  writeback source; 2'b01 = data memory (load).
- ex_rs1, ex_rs2  in  5  source registers currently in EX.
- ex_br_taken  in  1  branch/jump resolved taken in EX this cycle.
- pc_stall  out  1  hold PC.
- if_de_stall  out  1  hold IF/DE register.
- if_de_flush  out  1  zero IF/DE register (NOP).
- de_ex_flush  out  1  load bubble into DE/EX (ru_write=0, dm_write=0, br_op=0).
- fwd_a_sel, fwd_b_sel  out  2  ALU operand source: 00 register data, 01 MEM-stage ALU result, 10 WB-stage write data.
- stall_cnt, flush_cnt  out  CNT_W  statistics.

## Operation
- Shadow entry: {valid, rd, write, load}. "Live" = valid & write & rd≠0.
- Source match: de_valid & src_used & src==slot.rd & slot live.
- Stall condition:
  - FORWARDING=1: match against EX slot with load=1.
  - FORWARDING=0: match against the EX or MEM slot.
  - WB is never a hazard, because the register file writes before the DE read (negedge write).
- Branch taken has priority over stall:
  - if_de_flush=1, de_ex_flush=1.
  - pc_stall=0, if_de_stall=0.
- Stall without branch: pc_stall=1, if_de_stall=1, de_ex_flush=1.
- Otherwise all four controls are 0.
- Forwarding (per operand; rs = ex_rs1/ex_rs2):
  - MEM live & MEM.rd==rs & !MEM.load → 01.
  - Else WB live & WB.rd==rs → 10.
  - Else 00.
  - MEM has priority over WB for the same rd.
  - FORWARDING=0 forces 00.
- Shadow pipeline at each posedge: WB←MEM, MEM←EX.
  - EX←bubble (valid=0) if de_ex_flush.
  - Otherwise EX←{de_valid, de_rd, de_ru_write, de_ru_data_src==01}.
- Counters saturate at all-ones, no wrap:
  - stall_cnt +1 in each cycle where the stall condition holds and ex_br_taken=0.
  - flush_cnt +1 in each cycle where ex_br_taken=1.

## Timing
- All control and forwarding outputs are combinational from current inputs and shadow state; zero-cycle latency.
- Shadow and counters are registered; a decision affects the shadow at the next posedge.
- Load-use costs exactly 1 bubble. Next cycle the load is in MEM and the condition clears (FORWARDING=1). With FORWARDING=0, a RAW costs 2 bubbles.
- Stall and branch in the same cycle: the branch wins, and only flush_cnt increments.
- Reset (async, any time, including mid-stall):
  - All shadow slots become valid=0 and counters become 0 immediately.
  - While rst_n=0, every output is 0.
  - First posedge after release loads EX from decode normally.

## Structure
- Package riscv_pipe_pkg:
  - hazard_entry_t struct.
  - RU_SRC_DM = 2'b01.
  - FWD_RF/FWD_MEM/FWD_WB = 2'b00/01/10.
- Sub-module sat_counter #(W), instantiated twice (enable input, async active-low clear).
- Shadow pipeline and comparators stay in hazard_unit.

## Test plan
- Load-use: lw x5 in EX, decode add x6,x5,x7 with rs1_used → pc_stall=if_de_stall=de_ex_flush=1 for exactly 1 cycle; next cycle fwd_a_sel=10 for x5; stall_cnt=1.
- ALU forward: add x3 in MEM and x3 in WB, ex_rs1=3 → fwd_a_sel=01. With MEM.rd≠3 → 10. With ex_rs1=0 → 00.
- x0 immunity: load with rd=0 in EX, decode reads x0 → no stall, fwd 00.
- Branch plus stall collision: load-use and ex_br_taken=1 in the same cycle → if_de_flush=de_ex_flush=1, pc_stall=0; flush_cnt+1, stall_cnt unchanged.
- FORWARDING=0: add x4 then immediately sub x8,x4,x1 → 2 stall cycles, fwd sels stay 00, stall_cnt=2.
- Saturation and reset: with CNT_W=4, hold a stall for 20 cycles → stall_cnt=15. Assert rst_n low mid-stall → all outputs 0 asynchronously and counters 0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hazard_entry_t : one shadow-pipeline slot {valid, rd, write, load}
//   RU_SRC_DM      : writeback-source code that marks a load
//   FWD_*          : ALU operand forwarding selects
package riscv_pipe_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       write;
        logic       load;
    } hazard_entry_t;

    localparam logic [1:0] RU_SRC_DM = 2'b01;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // A slot only matters if it will really write a non-x0 register.
    function automatic logic entry_live(input hazard_entry_t e);
        return e.valid & e.write & (e.rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for hazard statistics.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   en    : count this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Interlock and forwarding controller for the five-stage pipeline.
// Tracks in-flight destinations in a three-slot shadow pipeline (EX/MEM/WB),
// raises stall/flush controls for PC, IF/DE and DE/EX, picks ALU operand
// forwarding paths and keeps saturating stall/flush statistics.
//   clk, rst_n                       : clock, async active-low reset
//   de_*                             : decode-stage instruction about to enter EX
//   ex_rs1, ex_rs2, ex_br_taken      : EX-stage sources and taken-branch flag
//   pc_stall, if_de_stall            : hold PC / IF-DE register
//   if_de_flush, de_ex_flush         : squash IF-DE / insert bubble into DE-EX
//   fwd_a_sel, fwd_b_sel             : ALU operand source selects
//   stall_cnt, flush_cnt             : statistics
module hazard_unit
    import riscv_pipe_pkg::*;
#(
    parameter bit FORWARDING = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [4:0]       de_rd,
    input  logic             de_ru_write,
    input  logic [1:0]       de_ru_data_src,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic             ex_br_taken,
    output logic             pc_stall,
    output logic             if_de_stall,
    output logic             if_de_flush,
    output logic             de_ex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_entry_t r_ex, r_mem, r_wb;

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_stall;

    function automatic logic src_hit(input logic valid, input logic used,
                                     input logic [4:0] rs, input hazard_entry_t e);
        return valid & used & (rs == e.rd) & entry_live(e);
    endfunction

    function automatic logic [1:0] fwd_pick(input logic [4:0] rs,
                                            input hazard_entry_t mem,
                                            input hazard_entry_t wb);
        // A load result is not available in MEM yet, so it can only come from WB.
        if (entry_live(mem) && (mem.rd == rs) && !mem.load) begin
            return FWD_MEM;
        end else if (entry_live(wb) && (wb.rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign w_hit_ex  = src_hit(de_valid, de_rs1_used, de_rs1, r_ex)
                     | src_hit(de_valid, de_rs2_used, de_rs2, r_ex);
    assign w_hit_mem = src_hit(de_valid, de_rs1_used, de_rs1, r_mem)
                     | src_hit(de_valid, de_rs2_used, de_rs2, r_mem);

    // WB never interlocks: the register file writes on the negedge, before DE reads.
    assign w_stall = FORWARDING ? (w_hit_ex & r_ex.load) : (w_hit_ex | w_hit_mem);

    always_comb begin
        pc_stall    = 1'b0;
        if_de_stall = 1'b0;
        if_de_flush = 1'b0;
        de_ex_flush = 1'b0;
        fwd_a_sel   = FWD_RF;
        fwd_b_sel   = FWD_RF;
        if (rst_n) begin
            if (ex_br_taken) begin
                if_de_flush = 1'b1;
                de_ex_flush = 1'b1;
            end else if (w_stall) begin
                pc_stall    = 1'b1;
                if_de_stall = 1'b1;
                de_ex_flush = 1'b1;
            end
            if (FORWARDING) begin
                fwd_a_sel = fwd_pick(ex_rs1, r_mem, r_wb);
                fwd_b_sel = fwd_pick(ex_rs2, r_mem, r_wb);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (de_ex_flush) begin
                r_ex <= '0;
            end else begin
                r_ex <= '{valid: de_valid, rd: de_rd, write: de_ru_write,
                          load: (de_ru_data_src == RU_SRC_DM)};
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_stall & ~ex_br_taken),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ex_br_taken),
        .count (flush_cnt)
    );

endmodule
